load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 20 ++
 rtl/load_store_unit_sat_counter.sv | 35 +++
 rtl/load_store_unit.sv | 215 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - Request op encodings (load/store).
//   - Memory mode pin encodings (read/write) used by the veda memory block.
//   - Sequencer state enum.
package lsu_pkg;

    localparam logic OP_LOAD    = 1'b0;
    localparam logic OP_STORE   = 1'b1;

    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_sat_counter.sv
// Saturating up-counter used for the load/store/error statistics.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   inc        : count one event this cycle
//   count      : current value, sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer sitting directly in front of the veda data memory.
// Accepts one request at a time, range-checks the word address, drives the
// memory pins from registers, captures synchronous read data and returns one
// tagged response per request.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   req_valid/req_ready             : request handshake from execute
//   req_op/req_addr/req_wdata/req_rd: request payload (0=load, 1=store)
//   rsp_valid/rsp_ready             : response handshake to writeback
//   rsp_data/rsp_rd/rsp_err         : response payload
//   mem_wdata/mem_raddr/mem_waddr   : memory data/address pins
//   mem_mode/mem_write              : memory mode (1=read) and write enable
//   mem_rdata                       : memory read data, valid one edge after
//                                     the read address is presented
//   busy                            : sequencer not idle
//   load_cnt/store_cnt/err_cnt      : saturating statistics counters
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int LEN   = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [LEN-1:0]   req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [4:0]       req_rd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [4:0]       rsp_rd,
    output logic             rsp_err,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [LEN-1:0]   mem_raddr,
    output logic [LEN-1:0]   mem_waddr,
    output logic             mem_mode,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // One extra bit so the bound check never truncates the address or DEPTH.
    localparam logic [LEN:0] DEPTH_X = (LEN+1)'(DEPTH);

    lsu_state_e       state_q,     state_d;
    logic             op_q,        op_d;
    logic [WIDTH-1:0] wdata_q,     wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic [4:0]       rsp_rd_q,    rsp_rd_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [LEN-1:0]   mem_raddr_q, mem_raddr_d;
    logic [LEN-1:0]   mem_waddr_q, mem_waddr_d;
    logic             mem_mode_q,  mem_mode_d;
    logic             mem_write_q, mem_write_d;

    logic             req_err;
    logic             load_inc;
    logic             store_inc;
    logic             err_inc;

    assign req_err = ({1'b0, req_addr} >= DEPTH_X);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        mem_wdata_d = mem_wdata_q;
        mem_raddr_d = mem_raddr_q;
        mem_waddr_d = mem_waddr_q;
        mem_mode_d  = mem_mode_q;
        mem_write_d = mem_write_q;
        load_inc    = 1'b0;
        store_inc   = 1'b0;
        err_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    wdata_d   = req_wdata;
                    rsp_rd_d  = req_rd;
                    rsp_err_d = req_err;
                    if (req_err) begin
                        // Out-of-range requests never touch the memory pins.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        err_inc     = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_raddr_d = req_addr;
                        if (req_op == OP_STORE) begin
                            mem_mode_d  = MODE_WRITE;
                            mem_write_d = 1'b1;
                            mem_waddr_d = req_addr;
                            mem_wdata_d = req_wdata;
                        end else begin
                            mem_mode_d  = MODE_READ;
                            mem_write_d = 1'b0;
                        end
                    end
                end
            end
            ISSUE: begin
                // Pins drop back to idle at the edge that commits the access.
                mem_mode_d  = MODE_READ;
                mem_write_d = 1'b0;
                mem_raddr_d = '0;
                mem_waddr_d = '0;
                mem_wdata_d = '0;
                if (op_q == OP_STORE) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = wdata_q;
                    store_inc   = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_rdata;
                load_inc    = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_LOAD;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_raddr_q <= '0;
            mem_waddr_q <= '0;
            mem_mode_q  <= MODE_READ;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            mem_wdata_q <= mem_wdata_d;
            mem_raddr_q <= mem_raddr_d;
            mem_waddr_q <= mem_waddr_d;
            mem_mode_q  <= mem_mode_d;
            mem_write_q <= mem_write_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_load_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (load_inc),
        .count (load_cnt)
    );

    sat_counter #(.W(CNT_W)) u_store_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (store_inc),
        .count (store_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (err_cnt)
    );

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_raddr = mem_raddr_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_mode  = mem_mode_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural synchronous memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_op;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [31:0] mem_wdata, mem_raddr, mem_waddr, mem_rdata;
    logic        mem_mode, mem_write, busy;
    logic [15:0] load_cnt, store_cnt, err_cnt;

    // Small-counter instance used to reach saturation quickly.
    logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_err;
    logic [31:0] s_req_addr, s_req_wdata, s_rsp_data;
    logic [4:0]  s_rsp_rd;
    logic [31:0] s_mem_wdata, s_mem_raddr, s_mem_waddr;
    logic        s_mem_mode, s_mem_write, s_busy;
    logic [1:0]  s_load_cnt, s_store_cnt, s_err_cnt;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .DEPTH(32), .LEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_mode(mem_mode), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .busy(busy), .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
    );

    load_store_unit #(.WIDTH(32), .DEPTH(32), .LEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(1'b1),
        .req_addr(s_req_addr), .req_wdata(s_req_wdata), .req_rd(5'd1),
        .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_data(s_rsp_data),
        .rsp_rd(s_rsp_rd), .rsp_err(s_rsp_err),
        .mem_wdata(s_mem_wdata), .mem_raddr(s_mem_raddr), .mem_waddr(s_mem_waddr),
        .mem_mode(s_mem_mode), .mem_write(s_mem_write), .mem_rdata(32'd0),
        .busy(s_busy), .load_cnt(s_load_cnt), .store_cnt(s_store_cnt), .err_cnt(s_err_cnt)
    );

    // Behavioural veda memory: synchronous write, registered read.
    logic [31:0] mem_arr [32] = '{default: '0};
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_waddr[4:0]] <= mem_wdata;
        mem_rdata <= mem_arr[mem_raddr[4:0]];
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        logic        is_store;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [32] = '{default: '0};
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          exp_load = 0, exp_store = 0, exp_err = 0;
    int          wr_cycles = 0, exp_wr = 0;
    int          hs_cyc = 0;
    bit          chk_gap = 0;
    bit          no_push = 0;
    bit          prev_valid = 0, prev_hs = 0;
    logic [37:0] prev_payload = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pushes expectations on accept, checks pins and responses.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (req_valid && req_ready) begin
                if (chk_gap) begin
                    chk("accept_after_handshake", cyc, hs_cyc + 1);
                    chk_gap = 0;
                end
                if (!no_push) begin
                    e.addr = req_addr; e.wdata = req_wdata; e.rd = req_rd;
                    e.is_store = req_op; e.acc = cyc;
                    if (req_addr >= 32'd32) begin
                        e.err = 1; e.data = '0; e.lat = 1; exp_err++;
                    end else if (req_op) begin
                        e.err = 0; e.data = req_wdata; e.lat = 2;
                        ref_mem[req_addr[4:0]] = req_wdata; exp_store++; exp_wr++;
                    end else begin
                        e.err = 0; e.data = ref_mem[req_addr[4:0]]; e.lat = 3; exp_load++;
                    end
                    q.push_back(e);
                end
            end
            if (mem_write) begin
                wr_cycles++;
                chk("mem_wr_mode", mem_mode, 0);
                chk("mem_wr_pending", q.size(), 1);
                if (q.size() > 0) begin
                    chk("mem_waddr", mem_waddr, q[0].addr);
                    chk("mem_wdata", mem_wdata, q[0].wdata);
                end
            end
            if (q.size() > 0 && !q[0].is_store && !q[0].err && cyc == q[0].acc + 1) begin
                chk("mem_raddr", mem_raddr, q[0].addr);
                chk("mem_rd_mode", {mem_mode, mem_write}, 2'b10);
            end
            if (rsp_valid) begin
                chk("rsp_blocks_req", req_ready, 0);
                if (!prev_valid) begin
                    chk("rsp_pending", q.size() > 0, 1);
                    if (q.size() > 0) chk("rsp_latency", cyc - q[0].acc, q[0].lat);
                end else if (!prev_hs) begin
                    chk("rsp_stable", {rsp_data, rsp_rd, rsp_err}, prev_payload);
                end
                if (rsp_ready && q.size() > 0) begin
                    e = q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_rd", rsp_rd, e.rd);
                    chk("rsp_err", rsp_err, e.err);
                    hs_cyc = cyc;
                end
            end
            prev_valid   = rsp_valid;
            prev_hs      = rsp_valid && rsp_ready;
            prev_payload = {rsp_data, rsp_rd, rsp_err};
        end
    end

    task automatic send(input logic op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd);
        int n = 0;
        req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_accepted", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", (q.size() == 0) && !busy, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        exp_load = 0; exp_store = 0; exp_err = 0;
        prev_valid = 0; prev_hs = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_load_cnt"},  load_cnt,  exp_load);
        chk({tag, "_store_cnt"}, store_cnt, exp_store);
        chk({tag, "_err_cnt"},   err_cnt,   exp_err);
        chk({tag, "_wr_cycles"}, wr_cycles, exp_wr);
    endtask

    initial begin
        int n;
        int w0;
        reset = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        rsp_ready = 1; s_req_valid = 0; s_req_addr = 0; s_req_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", {rsp_valid, rsp_data, rsp_rd, rsp_err}, '0);
        chk("rst_mem_ctl", {mem_write, mem_mode}, 2'b01);
        chk("rst_mem_bus", {mem_raddr, mem_waddr, mem_wdata}, '0);
        chk("rst_cnts", {load_cnt, store_cnt, err_cnt}, '0);
        reset = 0;

        // Store then load back the same word.
        send(1'b1, 32'd13, 32'd134, 5'd2);
        wait_done();
        send(1'b0, 32'd13, 32'd0, 5'd5);
        wait_done();
        chk("t1_one_write_cycle", wr_cycles, 1);
        chk_counts("t1");

        // Two stores to one word, the load sees the second.
        do_reset();
        send(1'b1, 32'd10, 32'd144, 5'd1);
        send(1'b1, 32'd10, 32'd170, 5'd3);
        send(1'b0, 32'd10, 32'd0,   5'd4);
        wait_done();
        chk("t2_store_cnt", store_cnt, 16'd2);
        chk("t2_load_cnt",  load_cnt,  16'd1);
        chk_counts("t2");

        // Out-of-range requests, plus the last legal word.
        w0 = wr_cycles;
        send(1'b0, 32'd32, 32'd0, 5'd7);
        send(1'b1, 32'd40, 32'd99, 5'd8);
        wait_done();
        chk("t3_err_cnt", err_cnt, 16'd2);
        chk("t3_no_write", wr_cycles, w0);
        send(1'b0, 32'h8000_0000, 32'd0, 5'd10);
        send(1'b1, 32'd31, 32'd55, 5'd11);
        send(1'b0, 32'd31, 32'd0,  5'd12);
        wait_done();
        chk_counts("t3");

        // Response back-pressure with a changing request waiting behind it.
        rsp_ready = 0;
        send(1'b0, 32'd13, 32'd0, 5'd6);
        req_valid = 1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            req_op = 1'($urandom); req_addr = $urandom_range(0, 40);
            req_wdata = $urandom; req_rd = 5'($urandom);
            n++;
        end
        chk("t4_rsp_seen", rsp_valid, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            req_op = 1'($urandom); req_addr = $urandom_range(0, 40);
            req_wdata = $urandom; req_rd = 5'($urandom);
        end
        chk("t4_rsp_held", rsp_valid, 1);
        req_op = 1; req_addr = 32'd20; req_wdata = 32'd77; req_rd = 5'd9;
        chk_gap = 1;
        rsp_ready = 1;
        send(1'b1, 32'd20, 32'd77, 5'd9);
        wait_done();
        chk("t4_gap_checked", chk_gap, 0);
        chk_counts("t4");

        // Reset while a store is in its issue cycle.
        no_push = 1;
        send(1'b1, 32'd3, 32'd200, 5'd13);
        chk("t5_write_in_issue", mem_write, 1);
        #1 reset = 1;
        #1;
        chk("t5_write_async_drop", mem_write, 0);
        chk("t5_idle", {busy, req_ready, rsp_valid}, 3'b010);
        chk("t5_cnts_zero", {load_cnt, store_cnt, err_cnt}, '0);
        clear_model();
        #1 reset = 0;
        no_push = 0;
        send(1'b0, 32'd3, 32'd0, 5'd14);
        wait_done();
        chk_counts("t5");

        // Counter saturation on the narrow-counter instance.
        for (int i = 0; i < 5; i++) begin
            n = 0;
            s_req_addr = i; s_req_wdata = i; s_req_valid = 1;
            @(negedge clk);
            while (!s_req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            s_req_valid = 0;
            repeat (3) @(posedge clk);
            #1;
            chk("sat_store_cnt", s_store_cnt, (i + 1 > 3) ? 3 : i + 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
